// File: rtl/control_modo_conf_if.sv
// control_modo_conf_if: button/timer inputs and mode outputs of the configuration-mode controller
interface control_modo_conf_if;
    logic       tick_1hz;
    logic       btn_hora;
    logic       btn_fecha;
    logic       btn_timer;
    logic       btn_salir;
    logic       timer_fin;
    logic [2:0] funcion_conf;
    logic       flag_mostrar_count;
    logic       alarma;
    logic       cambio_modo;

    modport master (
        output tick_1hz, btn_hora, btn_fecha, btn_timer, btn_salir, timer_fin,
        input  funcion_conf, flag_mostrar_count, alarma, cambio_modo
    );

    modport slave (
        input  tick_1hz, btn_hora, btn_fecha, btn_timer, btn_salir, timer_fin,
        output funcion_conf, flag_mostrar_count, alarma, cambio_modo
    );
endinterface

// File: rtl/control_modo_conf.sv
// control_modo_conf: selects time/date/timer configuration mode from buttons, with inactivity timeout and timer alarm
module control_modo_conf #(
    parameter int TIMEOUT_S = 30,
    parameter int ALARMA_S  = 10
) (
    input logic                 clk,
    input logic                 reset,
    control_modo_conf_if.slave  bus
);
    localparam int IW = $clog2(TIMEOUT_S + 1);
    localparam int AW = $clog2(ALARMA_S + 1);

    typedef enum logic [2:0] {
        IDLE       = 3'b000,
        CONF_HORA  = 3'b001,
        CONF_FECHA = 3'b010,
        CONF_TIMER = 3'b100
    } state_t;

    state_t          state, nxt;
    logic [3:0]      btn, prev, edges;
    logic [IW-1:0]   icnt;
    logic [AW-1:0]   acnt;
    logic            consume, timeout, flag, alarma, cambio;

    assign bus.funcion_conf       = state;
    assign bus.flag_mostrar_count = flag;
    assign bus.alarma             = alarma;
    assign bus.cambio_modo        = cambio;

    // Button edges (salir, hora, fecha, timer from msb) and next mode; edges during an alarm only silence it
    always_comb begin
        btn     = {bus.btn_salir, bus.btn_hora, bus.btn_fecha, bus.btn_timer};
        edges   = btn & ~prev;
        consume = alarma && (edges != 4'b0);
        timeout = (state != IDLE) && bus.tick_1hz && (icnt == IW'(TIMEOUT_S - 1));
        nxt     = edges[3] ? IDLE :
                  edges[2] ? CONF_HORA :
                  edges[1] ? CONF_FECHA :
                  edges[0] ? CONF_TIMER : state;
        nxt     = consume ? state : ((edges == 4'b0) && timeout) ? IDLE : nxt;
    end

    // Mode register, inactivity counter, countdown flag and alarm duration
    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= IDLE;
            prev   <= 4'hF;
            icnt   <= '0;
            acnt   <= '0;
            flag   <= 1'b0;
            alarma <= 1'b0;
            cambio <= 1'b0;
        end else begin
            prev   <= btn;
            state  <= nxt;
            cambio <= nxt != state;
            icnt   <= (nxt == IDLE || edges != 4'b0 || nxt != state) ? '0 :
                      bus.tick_1hz ? icnt + IW'(1) : icnt;
            if (bus.timer_fin)
                flag <= 1'b0;
            else if (nxt == CONF_TIMER && state != CONF_TIMER)
                flag <= 1'b0;
            else if (state == CONF_TIMER && !consume && edges[3])
                flag <= 1'b1;
            if (bus.timer_fin && flag) begin
                alarma <= 1'b1;
                acnt   <= '0;
            end else if (consume) begin
                alarma <= 1'b0;
                acnt   <= '0;
            end else if (alarma && bus.tick_1hz) begin
                alarma <= acnt != AW'(ALARMA_S - 1);
                acnt   <= (acnt == AW'(ALARMA_S - 1)) ? '0 : acnt + AW'(1);
            end
        end
    end
endmodule

// File: tb/tb_control_modo_conf.sv
// tb_control_modo_conf: scoreboard bench for the configuration-mode controller (TIMEOUT_S=3, ALARMA_S=2)
module tb_control_modo_conf;
    typedef struct {
        string      tag;
        logic [2:0] fc;
        logic       fl;
        logic       al;
        logic       cm;
    } exp_t;

    logic clk = 1'b0;
    logic reset;
    int   n_chk = 0;
    int   n_fail = 0;
    exp_t q[$];

    control_modo_conf_if bus();

    control_modo_conf #(.TIMEOUT_S(3), .ALARMA_S(2)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // b = {salir, hora, fecha, timer} levels held for this cycle; expected outputs after the next edge
    task automatic cyc(input logic [3:0] b, input logic tk, input logic tf,
                       input logic [2:0] fc, input logic fl, input logic al, input logic cm,
                       input string tag);
        exp_t e;
        {bus.btn_salir, bus.btn_hora, bus.btn_fecha, bus.btn_timer} = b;
        bus.tick_1hz  = tk;
        bus.timer_fin = tf;
        e.tag = tag; e.fc = fc; e.fl = fl; e.al = al; e.cm = cm;
        q.push_back(e);
        @(posedge clk);
        #1;
        e = q.pop_front();
        chk($sformatf("%s.funcion_conf", e.tag), 32'(bus.funcion_conf), 32'(e.fc));
        chk($sformatf("%s.flag", e.tag), 32'(bus.flag_mostrar_count), 32'(e.fl));
        chk($sformatf("%s.alarma", e.tag), 32'(bus.alarma), 32'(e.al));
        chk($sformatf("%s.cambio", e.tag), 32'(bus.cambio_modo), 32'(e.cm));
        bus.tick_1hz  = 1'b0;
        bus.timer_fin = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        {bus.btn_salir, bus.btn_hora, bus.btn_fecha, bus.btn_timer} = 4'b0;
        bus.tick_1hz  = 1'b0;
        bus.timer_fin = 1'b0;
        cyc(4'b0000, 0, 0, 3'b000, 0, 0, 0, "reset");
        cyc(4'b0000, 0, 0, 3'b000, 0, 0, 0, "reset2");
        reset = 1'b0;
        cyc(4'b0000, 0, 0, 3'b000, 0, 0, 0, "idle");
        cyc(4'b1000, 0, 0, 3'b000, 0, 0, 0, "idle_salir");
        cyc(4'b0000, 0, 0, 3'b000, 0, 0, 0, "idle2");
        cyc(4'b0100, 0, 0, 3'b001, 0, 0, 1, "hora");
        cyc(4'b0100, 0, 0, 3'b001, 0, 0, 0, "hora_held");
        cyc(4'b0000, 0, 0, 3'b001, 0, 0, 0, "hora_rel");
        cyc(4'b0010, 0, 0, 3'b010, 0, 0, 1, "fecha");
        cyc(4'b0000, 0, 0, 3'b010, 0, 0, 0, "fecha_rel");
        cyc(4'b1100, 0, 0, 3'b000, 0, 0, 1, "prio_salir");
        cyc(4'b0000, 0, 0, 3'b000, 0, 0, 0, "prio_rel");
        cyc(4'b0100, 0, 0, 3'b001, 0, 0, 1, "to_hora");
        cyc(4'b0000, 1, 0, 3'b001, 0, 0, 0, "tick1");
        cyc(4'b0000, 1, 0, 3'b001, 0, 0, 0, "tick2");
        cyc(4'b0100, 0, 0, 3'b001, 0, 0, 0, "own_btn_restart");
        cyc(4'b0000, 1, 0, 3'b001, 0, 0, 0, "rtick1");
        cyc(4'b0000, 1, 0, 3'b001, 0, 0, 0, "rtick2");
        cyc(4'b0000, 1, 0, 3'b000, 0, 0, 1, "timeout");
        cyc(4'b0000, 1, 0, 3'b000, 0, 0, 0, "idle_tick");
        cyc(4'b0001, 0, 0, 3'b100, 0, 0, 1, "timer");
        cyc(4'b0000, 0, 0, 3'b100, 0, 0, 0, "timer_rel");
        cyc(4'b1000, 0, 0, 3'b000, 1, 0, 1, "arm");
        cyc(4'b0000, 0, 0, 3'b000, 1, 0, 0, "armed");
        cyc(4'b0000, 0, 1, 3'b000, 0, 1, 0, "fin");
        cyc(4'b0000, 1, 0, 3'b000, 0, 1, 0, "al_tick1");
        cyc(4'b0000, 1, 0, 3'b000, 0, 0, 0, "al_tick2");
        cyc(4'b0000, 0, 1, 3'b000, 0, 0, 0, "fin_unarmed");
        cyc(4'b0001, 0, 0, 3'b100, 0, 0, 1, "timer2");
        cyc(4'b0000, 0, 0, 3'b100, 0, 0, 0, "timer2_rel");
        cyc(4'b1000, 0, 0, 3'b000, 1, 0, 1, "arm2");
        cyc(4'b0000, 0, 1, 3'b000, 0, 1, 0, "fin2");
        cyc(4'b0100, 0, 0, 3'b000, 0, 0, 0, "consume");
        cyc(4'b0000, 0, 0, 3'b000, 0, 0, 0, "consume_rel");
        cyc(4'b0001, 0, 0, 3'b100, 0, 0, 1, "timer3");
        cyc(4'b0100, 0, 0, 3'b001, 0, 0, 1, "jump_hora");
        cyc(4'b0000, 0, 0, 3'b001, 0, 0, 0, "jump_rel");
        cyc(4'b1000, 0, 0, 3'b000, 0, 0, 1, "salir_hora");
        cyc(4'b0000, 0, 0, 3'b000, 0, 0, 0, "salir_rel");
        cyc(4'b0100, 0, 0, 3'b001, 0, 0, 1, "pre_reset");
        cyc(4'b0000, 0, 0, 3'b001, 0, 0, 0, "pre_reset_rel");
        reset = 1'b1;
        cyc(4'b0100, 0, 0, 3'b000, 0, 0, 0, "mid_reset");
        reset = 1'b0;
        cyc(4'b0100, 0, 0, 3'b000, 0, 0, 0, "held_release");
        cyc(4'b0100, 0, 0, 3'b000, 0, 0, 0, "held_release2");
        cyc(4'b0000, 0, 0, 3'b000, 0, 0, 0, "release");
        cyc(4'b0100, 0, 0, 3'b001, 0, 0, 1, "hora_after");
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
